// File: rtl/prewitt_window_ctrl_if.sv
// Raster pixel stream into the Prewitt window controller.
// The master drives valid/sof/data, and the controller answers with ready.
interface prewitt_window_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              s_valid;
   logic              s_ready;
   logic              s_sof;
   logic [DATA_W-1:0] s_data;

   modport master (output s_valid, s_sof, s_data, input s_ready);
   modport slave  (input s_valid, s_sof, s_data, output s_ready);
endinterface

// File: rtl/prewitt_window_ctrl.sv
// Front-end sequencer for the 3x3 Prewitt window. It tracks the raster position and
// drives two rotating line buffers, the window shift strobe and the interior-valid flag.
module prewitt_window_ctrl #(
   parameter int PIC_WIDTH  = 320,
   parameter int PIC_HEIGHT = 240,
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prewitt_window_ctrl_if.slave  strm,
   input  logic                  stall,
   output logic [ADDR_W-1:0]     lb_addr,
   output logic                  lb_wr_en,
   output logic                  lb_sel,
   output logic [DATA_W-1:0]     pix_out,
   output logic                  mat_valid,
   output logic                  win_valid,
   output logic [ADDR_W-1:0]     out_col,
   output logic [ADDR_W-1:0]     out_row,
   output logic                  frame_done,
   output logic                  err_sof
);

   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(PIC_WIDTH - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(PIC_HEIGHT - 1);
   localparam logic [ADDR_W-1:0] ROW_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] POS_TWO  = ADDR_W'(2);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] col, row;
   logic              sel_q;

   logic [ADDR_W-1:0] cur_col, cur_row;
   logic              cur_sel;
   logic              beat, take, restart, err_det, col_last, row_last;

   assign strm.s_ready = !stall && (state != DONE);
   assign frame_done   = (state == DONE);

   // A beat carrying s_sof restarts the raster at col 0/row 0, so every position
   // decision uses the restarted coordinates instead of the stored counters.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through this block infers a latch.
      state_nxt = state;
      beat      = strm.s_valid && strm.s_ready;
      take      = beat && ((state != IDLE) || strm.s_sof);
      restart   = take && strm.s_sof;
      err_det   = restart && (state != IDLE) && ((col != '0) || (row != '0));
      cur_col   = restart ? '0   : col;
      cur_row   = restart ? '0   : row;
      cur_sel   = restart ? 1'b0 : sel_q;
      col_last  = (cur_col == COL_LAST);
      row_last  = (cur_row == ROW_LAST);

      case (state)
         IDLE: if (take) state_nxt = FILL;
         FILL: begin
            if (restart)                                       state_nxt = FILL;
            else if (take && col_last && (cur_row == ROW_ONE)) state_nxt = RUN;
         end
         RUN: begin
            if (restart)                          state_nxt = FILL;
            else if (take && col_last && row_last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // The buffer rotation flips on each line wrap and applies from the next beat onward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col   <= '0;
         row   <= '0;
         sel_q <= 1'b0;
      end else if (take) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         if (col_last) begin
            col   <= '0;
            row   <= row_last ? '0 : cur_row + 1'b1;
            sel_q <= ~cur_sel;
         end else begin
            col   <= cur_col + 1'b1;
            row   <= cur_row;
            sel_q <= cur_sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mat_valid <= 1'b0;
         lb_wr_en  <= 1'b0;
         win_valid <= 1'b0;
         err_sof   <= 1'b0;
         lb_addr   <= '0;
         out_col   <= '0;
         out_row   <= '0;
         pix_out   <= '0;
         lb_sel    <= 1'b0;
      end else begin
         mat_valid <= take;
         lb_wr_en  <= take;
         err_sof   <= err_det;
         win_valid <= take && (state == RUN) && (cur_row >= POS_TWO) && (cur_col >= POS_TWO);
         if (take) begin
            lb_addr <= cur_col;
            out_col <= cur_col;
            out_row <= cur_row;
            pix_out <= strm.s_data;
            lb_sel  <= cur_sel;
         end
      end
   end

endmodule

// File: tb/tb_prewitt_window_ctrl.sv
// Self-checking bench for prewitt_window_ctrl. A 4x3 instance is compared against a
// raster-position reference model, and a 4x4 instance exercises the buffer rotation.
module tb_prewitt_window_ctrl;

   localparam int TW = 4;
   localparam int TH = 3;
   localparam int DW = 8;
   localparam int AW = 9;

   typedef struct packed {
      logic          mat;
      logic          wr;
      logic          win;
      logic          err;
      logic          done;
      logic          sel;
      logic [AW-1:0] addr;
      logic [AW-1:0] col;
      logic [AW-1:0] row;
      logic [DW-1:0] pix;
   } obs_t;

   typedef struct packed {
      logic        in_frame;
      logic        done;
      logic [31:0] pos;
      obs_t        exp;
   } model_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic stall, stall_b;

   logic [AW-1:0] lb_addr, out_col, out_row;
   logic [DW-1:0] pix_out;
   logic          lb_wr_en, lb_sel, mat_valid, win_valid, frame_done, err_sof;

   logic [AW-1:0] b_lb_addr, b_out_col, b_out_row;
   logic [DW-1:0] b_pix_out;
   logic          b_lb_wr_en, b_lb_sel, b_mat_valid, b_win_valid, b_frame_done, b_err_sof;

   prewitt_window_ctrl_if #(.DATA_W(DW)) if0 ();
   prewitt_window_ctrl_if #(.DATA_W(DW)) if1 ();

   prewitt_window_ctrl #(.PIC_WIDTH(TW), .PIC_HEIGHT(TH), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .strm(if0.slave), .stall(stall),
      .lb_addr(lb_addr), .lb_wr_en(lb_wr_en), .lb_sel(lb_sel), .pix_out(pix_out),
      .mat_valid(mat_valid), .win_valid(win_valid), .out_col(out_col), .out_row(out_row),
      .frame_done(frame_done), .err_sof(err_sof)
   );

   prewitt_window_ctrl #(.PIC_WIDTH(4), .PIC_HEIGHT(4), .DATA_W(DW), .ADDR_W(AW)) dut_b (
      .clk(clk), .rst_n(rst_n), .strm(if1.slave), .stall(stall_b),
      .lb_addr(b_lb_addr), .lb_wr_en(b_lb_wr_en), .lb_sel(b_lb_sel), .pix_out(b_pix_out),
      .mat_valid(b_mat_valid), .win_valid(b_win_valid), .out_col(b_out_col), .out_row(b_out_row),
      .frame_done(b_frame_done), .err_sof(b_err_sof)
   );

   obs_t   got, b_got;
   model_t m;
   logic   exp_ready;
   int     checks   = 0;
   int     failures = 0;

   assign got   = {mat_valid, lb_wr_en, win_valid, err_sof, frame_done, lb_sel,
                   lb_addr, out_col, out_row, pix_out};
   assign b_got = {b_mat_valid, b_lb_wr_en, b_win_valid, b_err_sof, b_frame_done, b_lb_sel,
                   b_lb_addr, b_out_col, b_out_row, b_pix_out};

   always #5 clk = ~clk;

   // Reference: a frame is a linear pixel index; col/row/buffer come from div/mod.
   function automatic model_t model_next(model_t cur, logic v, logic sof, logic [DW-1:0] d,
                                         logic st);
      model_t n = cur;
      int     c, r;
      n.exp.mat = 1'b0;
      n.exp.wr  = 1'b0;
      n.exp.win = 1'b0;
      n.exp.err = 1'b0;
      n.done    = 1'b0;
      if (v && !st && !cur.done && (sof || cur.in_frame)) begin
         n.exp.err = sof && cur.in_frame && (cur.pos != '0);
         if (sof) n.pos = '0;
         c = int'(n.pos) % TW;
         r = int'(n.pos) / TW;
         n.exp.mat  = 1'b1;
         n.exp.wr   = 1'b1;
         n.exp.win  = (r >= 2) && (c >= 2);
         n.exp.sel  = (r % 2) == 1;
         n.exp.addr = AW'(c);
         n.exp.col  = AW'(c);
         n.exp.row  = AW'(r);
         n.exp.pix  = d;
         n.in_frame = 1'b1;
         n.pos      = n.pos + 32'd1;
         if (n.pos == 32'(TW * TH)) begin
            n.in_frame = 1'b0;
            n.pos      = '0;
            n.done     = 1'b1;
         end
      end
      n.exp.done = n.done;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_next(m, if0.s_valid, if0.s_sof, if0.s_data, stall);
   end

   assign exp_ready = !stall && !m.done;

   task automatic set_in(input logic v, input logic sof, input logic st);
      if0.s_valid = v;
      if0.s_sof   = sof;
      if0.s_data  = DW'($urandom);
      stall       = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_in(1'b0, 1'b0, 1'b0);
      if1.s_valid = 1'b0;
      if1.s_sof   = 1'b0;
      if1.s_data  = '0;
      stall_b     = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      checks++; if (got !== '0) begin failures++; $display("FAIL reset_outputs: got=%h want=0", got); end
      checks++; if (if0.s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got=%b want=1", if0.s_ready); end
      stall = 1'b1;
      #1;
      checks++; if (if0.s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_stall: got=%b want=0", if0.s_ready); end
      stall = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      checks++; if (got !== '0) begin failures++; $display("FAIL idle_after_reset: got=%h want=0", got); end
   endtask

   task automatic test_frame();
      int mats = 0;
      int wins = 0;
      for (int i = 0; i < 12; i++) begin
         set_in(1'b1, i == 0, 1'b0);
         #1;
         checks++; if (if0.s_ready !== 1'b1) begin failures++; $display("FAIL frame_ready[%0d]: got=%b want=1", i, if0.s_ready); end
         tick();
         checks++; if (got !== m.exp) begin failures++; $display("FAIL frame_beat[%0d]: got=%h want=%h", i, got, m.exp); end
         mats += int'(mat_valid);
         if (win_valid) begin
            wins++;
            checks++;
            if (i < 10 || out_row !== AW'(2) || out_col !== AW'(i - 8)) begin
               failures++; $display("FAIL frame_win_pos[%0d]: got row=%0d col=%0d", i, out_row, out_col);
            end
         end
      end
      set_in(1'b0, 1'b0, 1'b0);
      #1;
      checks++; if (frame_done !== 1'b1 || if0.s_ready !== 1'b0) begin failures++; $display("FAIL frame_done: got done=%b ready=%b want 1/0", frame_done, if0.s_ready); end
      tick();
      checks++; if (got !== m.exp) begin failures++; $display("FAIL frame_after_done: got=%h want=%h", got, m.exp); end
      checks++; if (mats != 12 || wins != 2) begin failures++; $display("FAIL frame_totals: got mat=%0d win=%0d want 12/2", mats, wins); end
   endtask

   task automatic test_stall();
      int mats = 0;
      int wins = 0;
      for (int c = 0; c < 16; c++) begin
         set_in(c < 15, c == 0, (c >= 6) && (c <= 8));
         #1;
         checks++; if (if0.s_ready !== exp_ready) begin failures++; $display("FAIL stall_ready[%0d]: got=%b want=%b", c, if0.s_ready, exp_ready); end
         tick();
         checks++; if (got !== m.exp) begin failures++; $display("FAIL stall_cycle[%0d]: got=%h want=%h", c, got, m.exp); end
         if (c == 9) begin
            checks++; if (out_col !== AW'(2) || out_row !== AW'(1)) begin failures++; $display("FAIL stall_resume: got col=%0d row=%0d want 2/1", out_col, out_row); end
         end
         mats += int'(mat_valid);
         wins += int'(win_valid);
      end
      checks++; if (mats != 12 || wins != 2) begin failures++; $display("FAIL stall_totals: got mat=%0d win=%0d want 12/2", mats, wins); end
   endtask

   task automatic test_idle_drop();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 1'b0);
         tick();
         checks++; if (mat_valid !== 1'b0 || lb_wr_en !== 1'b0 || got !== m.exp) begin failures++; $display("FAIL idle_drop[%0d]: got=%h want=%h", i, got, m.exp); end
      end
      set_in(1'b1, 1'b1, 1'b0);
      tick();
      checks++; if (out_col !== '0 || out_row !== '0 || lb_wr_en !== 1'b1) begin failures++; $display("FAIL idle_sof: got col=%0d row=%0d wr=%b want 0/0/1", out_col, out_row, lb_wr_en); end
      for (int i = 0; i < 12; i++) begin
         set_in(i < 11, 1'b0, 1'b0);
         tick();
         checks++; if (got !== m.exp) begin failures++; $display("FAIL idle_rest[%0d]: got=%h want=%h", i, got, m.exp); end
      end
   endtask

   task automatic test_sof_restart();
      for (int i = 0; i < 6; i++) begin
         set_in(1'b1, i == 0, 1'b0);
         tick();
         checks++; if (got !== m.exp) begin failures++; $display("FAIL restart_pre[%0d]: got=%h want=%h", i, got, m.exp); end
      end
      set_in(1'b1, 1'b1, 1'b0);
      tick();
      checks++; if (err_sof !== 1'b1 || out_col !== '0 || out_row !== '0 || lb_sel !== 1'b0) begin
         failures++; $display("FAIL restart_beat: got err=%b col=%0d row=%0d sel=%b want 1/0/0/0", err_sof, out_col, out_row, lb_sel);
      end
      checks++; if (got !== m.exp) begin failures++; $display("FAIL restart_model: got=%h want=%h", got, m.exp); end
      for (int i = 0; i < 11; i++) begin
         set_in(1'b1, 1'b0, 1'b0);
         tick();
         checks++; if (got !== m.exp) begin failures++; $display("FAIL restart_post[%0d]: got=%h want=%h", i, got, m.exp); end
         checks++; if (frame_done !== logic'(i == 10)) begin failures++; $display("FAIL restart_done[%0d]: got=%b", i, frame_done); end
      end
      set_in(1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (got !== m.exp) begin failures++; $display("FAIL restart_end: got=%h want=%h", got, m.exp); end
   endtask

   task automatic test_back_to_back();
      int k     = 0;
      int cyc   = 0;
      int dones = 0;
      int mats  = 0;
      while (k < 24 && cyc < 60) begin
         if0.s_valid = 1'b1;
         if0.s_sof   = (k % 12) == 0;
         if0.s_data  = DW'(k * 29 + 7);
         stall       = 1'b0;
         #1;
         checks++; if (if0.s_ready !== exp_ready) begin failures++; $display("FAIL b2b_ready[%0d]: got=%b want=%b", cyc, if0.s_ready, exp_ready); end
         tick();
         cyc++;
         checks++; if (got !== m.exp) begin failures++; $display("FAIL b2b_cycle[%0d]: got=%h want=%h", cyc, got, m.exp); end
         if (m.exp.mat) k++;
         mats  += int'(mat_valid);
         dones += int'(frame_done);
      end
      checks++; if (k < 24) begin failures++; $display("FAIL b2b_timeout: got %0d pixels want 24", k); end
      set_in(1'b0, 1'b0, 1'b0);
      tick();
      dones += int'(frame_done);
      checks++; if (mats != 24 || dones != 2) begin failures++; $display("FAIL b2b_totals: got mat=%0d done=%0d want 24/2", mats, dones); end
   endtask

   task automatic test_lb_sel();
      for (int i = 0; i < 16; i++) begin
         if1.s_valid = 1'b1;
         if1.s_sof   = (i == 0);
         if1.s_data  = DW'($urandom);
         stall_b     = 1'b0;
         tick();
         checks++;
         if (b_got.sel !== logic'(((i / 4) % 2) == 1) || b_got.addr !== AW'(i % 4) ||
             b_got.row !== AW'(i / 4) || b_got.mat !== 1'b1) begin
            failures++; $display("FAIL lb_sel[%0d]: got sel=%b addr=%0d row=%0d", i, b_got.sel, b_got.addr, b_got.row);
         end
      end
      if1.s_valid = 1'b0;
      checks++; if (b_got.done !== 1'b1 || b_got.win !== 1'b1) begin failures++; $display("FAIL lb_sel_done: got done=%b win=%b want 1/1", b_got.done, b_got.win); end
      tick();
   endtask

   task automatic test_random();
      logic v, sof, st;
      for (int c = 0; c < 600; c++) begin
         v   = ($urandom % 4) != 0;
         st  = ($urandom % 5) == 0;
         sof = m.in_frame ? (($urandom % 40) == 0) : (($urandom % 2) == 0);
         set_in(v, sof, st);
         #1;
         checks++; if (if0.s_ready !== exp_ready) begin failures++; $display("FAIL rand_ready[%0d]: got=%b want=%b", c, if0.s_ready, exp_ready); end
         tick();
         checks++; if (got !== m.exp) begin failures++; $display("FAIL rand_cycle[%0d]: got=%h want=%h", c, got, m.exp); end
      end
   endtask

   task automatic test_reset_midframe();
      set_in(1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, i == 0, 1'b0);
         tick();
         checks++; if (got !== m.exp) begin failures++; $display("FAIL midrst_pre[%0d]: got=%h want=%h", i, got, m.exp); end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (got !== '0) begin failures++; $display("FAIL midrst_async: got=%h want=0", got); end
      checks++; if (if0.s_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got=%b want=1", if0.s_ready); end
      #2 rst_n = 1'b1;
      set_in(1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (mat_valid !== 1'b0 || lb_wr_en !== 1'b0 || got !== '0) begin failures++; $display("FAIL midrst_nosof: got=%h want=0", got); end
      set_in(1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_frame();
      test_stall();
      test_idle_drop();
      test_sof_restart();
      test_back_to_back();
      test_lb_sel();
      test_random();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
